// File: rtl/fullcon_seq_mac_if.sv
// rtl/fullcon_seq_mac_if.sv - vector-in / neuron-result-out handshake bundle for fullcon_seq_mac
interface fullcon_seq_mac_if #(
   parameter int DEPTH_IN     = 12,
   parameter int N_OUT        = 4,
   parameter int WIDTH_DATA   = 16,
   parameter int WIDTH_KERNEL = 8
);
   localparam int WIDTH_ACC = WIDTH_DATA + WIDTH_KERNEL + $clog2(DEPTH_IN) + 1;
   localparam int WIDTH_IDX = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic                                   in_valid;
   logic                                   in_ready;
   logic [WIDTH_DATA*DEPTH_IN-1:0]         data_in;
   logic [WIDTH_KERNEL*DEPTH_IN*N_OUT-1:0] kernel_in;
   logic [WIDTH_ACC*N_OUT-1:0]             bias_in;
   logic                                   out_valid;
   logic                                   out_ready;
   logic [WIDTH_ACC-1:0]                   data_o;
   logic [WIDTH_IDX-1:0]                   out_idx;
   logic                                   out_last;

   modport master (
      output in_valid, data_in, kernel_in, bias_in, out_ready,
      input  in_ready, out_valid, data_o, out_idx, out_last
   );

   modport slave (
      input  in_valid, data_in, kernel_in, bias_in, out_ready,
      output in_ready, out_valid, data_o, out_idx, out_last
   );
endinterface

// File: rtl/fullcon_seq_mac.sv
// rtl/fullcon_seq_mac.sv - sequential fully-connected layer, LANES multiply-accumulates per cycle
module fullcon_seq_mac #(
   parameter int DEPTH_IN     = 12,
   parameter int N_OUT        = 4,
   parameter int LANES        = 4,
   parameter int WIDTH_DATA   = 16,
   parameter int WIDTH_KERNEL = 8,
   parameter int RELU_EN      = 0
) (
   input logic               clk,
   input logic               rst,
   fullcon_seq_mac_if.slave  bus
);
   localparam int WIDTH_ACC   = WIDTH_DATA + WIDTH_KERNEL + $clog2(DEPTH_IN) + 1;
   localparam int WIDTH_PROD  = WIDTH_DATA + WIDTH_KERNEL;
   localparam int WIDTH_IDX   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int CHUNKS      = DEPTH_IN / LANES;
   localparam int WIDTH_CHUNK = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

   state_t                                 state_q, state_d;
   logic [WIDTH_DATA*DEPTH_IN-1:0]         data_q, data_d;
   logic [WIDTH_KERNEL*DEPTH_IN*N_OUT-1:0] kernel_q, kernel_d;
   logic [WIDTH_ACC*N_OUT-1:0]             bias_q, bias_d;
   logic signed [WIDTH_ACC-1:0]            acc_q, acc_d;
   logic [WIDTH_CHUNK-1:0]                 chunk_q, chunk_d;
   logic [WIDTH_IDX-1:0]                   n_q, n_d;

   logic signed [WIDTH_ACC-1:0]            mac_sum;
   logic signed [WIDTH_PROD-1:0]           prod;
   int                                     elem;

   // One chunk of LANES products, each sign-extended before it joins the accumulator
   always_comb begin
      mac_sum = acc_q;
      prod    = '0;
      elem    = 0;
      for (int l = 0; l < LANES; l++) begin
         elem    = int'(chunk_q) * LANES + l;
         prod    = $signed(data_q[elem*WIDTH_DATA +: WIDTH_DATA])
                 * $signed(kernel_q[(int'(n_q)*DEPTH_IN + elem)*WIDTH_KERNEL +: WIDTH_KERNEL]);
         mac_sum = mac_sum + {{(WIDTH_ACC-WIDTH_PROD){prod[WIDTH_PROD-1]}}, prod};
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      kernel_d = kernel_q;
      bias_d   = bias_q;
      acc_d    = acc_q;
      chunk_d  = chunk_q;
      n_d      = n_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               data_d   = bus.data_in;
               kernel_d = bus.kernel_in;
               bias_d   = bus.bias_in;
               acc_d    = bus.bias_in[WIDTH_ACC-1:0];
               chunk_d  = '0;
               n_d      = '0;
               state_d  = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = mac_sum;
            if (chunk_q == WIDTH_CHUNK'(CHUNKS - 1)) begin
               chunk_d = '0;
               state_d = ST_OUT;
            end else begin
               chunk_d = chunk_q + WIDTH_CHUNK'(1);
            end
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               if (n_q == WIDTH_IDX'(N_OUT - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  n_d     = n_q + WIDTH_IDX'(1);
                  acc_d   = bias_q[int'(n_d)*WIDTH_ACC +: WIDTH_ACC];
                  state_d = ST_MAC;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         chunk_q <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         chunk_q <= chunk_d;
         n_q     <= n_d;
      end
   end

   // Operand store only ever loads on an accepted vector, so it needs no reset
   always_ff @(posedge clk) begin
      data_q   <= data_d;
      kernel_q <= kernel_d;
      bias_q   <= bias_d;
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_OUT);
   assign bus.data_o    = ((RELU_EN != 0) && acc_q[WIDTH_ACC-1]) ? '0 : acc_q;
   assign bus.out_idx   = n_q;
   assign bus.out_last  = (state_q == ST_OUT) && (n_q == WIDTH_IDX'(N_OUT - 1));
endmodule

// File: tb/tb_fullcon_seq_mac.sv
// tb/tb_fullcon_seq_mac.sv - scoreboard bench for fullcon_seq_mac (default, ReLU and single-neuron wide variants)
module tb_fullcon_seq_mac;
   localparam int WA = 29;

   typedef struct {
      logic [WA-1:0] val;
      int            idx;
      bit            last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fullcon_seq_mac_if #(.DEPTH_IN(12), .N_OUT(4), .WIDTH_DATA(16), .WIDTH_KERNEL(8)) a_if ();
   fullcon_seq_mac_if #(.DEPTH_IN(12), .N_OUT(4), .WIDTH_DATA(16), .WIDTH_KERNEL(8)) b_if ();
   fullcon_seq_mac_if #(.DEPTH_IN(12), .N_OUT(1), .WIDTH_DATA(16), .WIDTH_KERNEL(8)) c_if ();

   logic [2:0]          vld  = 3'b000;
   logic [2:0]          ordy = 3'b000;
   logic [2:0]          rdy;
   logic [16*12-1:0]    pk_data;
   logic [8*12*4-1:0]   pk_kern;
   logic [WA*4-1:0]     pk_bias;

   assign a_if.in_valid  = vld[0];
   assign b_if.in_valid  = vld[1];
   assign c_if.in_valid  = vld[2];
   assign a_if.out_ready = ordy[0];
   assign b_if.out_ready = ordy[1];
   assign c_if.out_ready = ordy[2];
   assign a_if.data_in   = pk_data;
   assign b_if.data_in   = pk_data;
   assign c_if.data_in   = pk_data;
   assign a_if.kernel_in = pk_kern;
   assign b_if.kernel_in = pk_kern;
   assign c_if.kernel_in = pk_kern[8*12-1:0];
   assign a_if.bias_in   = pk_bias;
   assign b_if.bias_in   = pk_bias;
   assign c_if.bias_in   = pk_bias[WA-1:0];
   assign rdy = {c_if.in_ready, b_if.in_ready, a_if.in_ready};

   fullcon_seq_mac #(.DEPTH_IN(12), .N_OUT(4), .LANES(4), .WIDTH_DATA(16), .WIDTH_KERNEL(8), .RELU_EN(0))
      u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   fullcon_seq_mac #(.DEPTH_IN(12), .N_OUT(4), .LANES(4), .WIDTH_DATA(16), .WIDTH_KERNEL(8), .RELU_EN(1))
      u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
   fullcon_seq_mac #(.DEPTH_IN(12), .N_OUT(1), .LANES(12), .WIDTH_DATA(16), .WIDTH_KERNEL(8), .RELU_EN(0))
      u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

   int     data_v[12];
   int     kern_v[4][12];
   longint bias_v[4];
   exp_t   qa[$], qb[$], qc[$];
   int     ta[$], tb_s[$], tc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [WA-1:0] model(input int n, input bit relu);
      longint     s;
      logic [63:0] t;
      s = bias_v[n];
      for (int i = 0; i < 12; i++) s += longint'(data_v[i]) * longint'(kern_v[n][i]);
      if (relu && s < 0) s = 0;
      t = s;
      return t[WA-1:0];
   endfunction

   task automatic pack_vec();
      int     t;
      longint b;
      for (int i = 0; i < 12; i++) begin
         t = data_v[i];
         pk_data[i*16 +: 16] = t[15:0];
      end
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 12; i++) begin
            t = kern_v[n][i];
            pk_kern[(n*12+i)*8 +: 8] = t[7:0];
         end
         b = bias_v[n];
         pk_bias[n*WA +: WA] = b[WA-1:0];
      end
   endtask

   task automatic rand_vec();
      for (int i = 0; i < 12; i++) data_v[i] = int'($urandom_range(0, 65535)) - 32768;
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 12; i++) kern_v[n][i] = int'($urandom_range(0, 255)) - 128;
         bias_v[n] = longint'(int'($urandom_range(0, 2000000))) - 1000000;
      end
   endtask

   task automatic check_out(input int w, input logic [WA-1:0] d, input int idx, input logic last);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (w)
         0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; ta.push_back(cyc + 1); end
         1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; tb_s.push_back(cyc + 1); end
         default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; tc.push_back(cyc + 1); end
      endcase
      chk($sformatf("u%0d_result_expected", w), 64'(have), 64'd1);
      if (have) begin
         chk($sformatf("u%0d_data_o_idx%0d", w, e.idx), 64'(d), 64'(e.val));
         chk($sformatf("u%0d_out_idx", w), 64'(idx), 64'(e.idx));
         chk($sformatf("u%0d_out_last_idx%0d", w, e.idx), 64'(last), 64'(e.last));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (a_if.out_valid && a_if.out_ready) check_out(0, a_if.data_o, int'(a_if.out_idx), a_if.out_last);
         if (b_if.out_valid && b_if.out_ready) check_out(1, b_if.data_o, int'(b_if.out_idx), b_if.out_last);
         if (c_if.out_valid && c_if.out_ready) check_out(2, c_if.data_o, int'(c_if.out_idx), c_if.out_last);
      end
   end

   task automatic send(input int w, output int stamp);
      int k;
      pack_vec();
      case (w)
         0: for (int n = 0; n < 4; n++) qa.push_back('{val: model(n, 1'b0), idx: n, last: (n == 3)});
         1: for (int n = 0; n < 4; n++) qb.push_back('{val: model(n, 1'b1), idx: n, last: (n == 3)});
         default: qc.push_back('{val: model(0, 1'b0), idx: 0, last: 1'b1});
      endcase
      vld[w] = 1'b1;
      k = 0;
      while (!rdy[w] && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk($sformatf("u%0d_in_ready_before_send", w), 64'(rdy[w]), 64'd1);
      @(posedge clk);
      #1;
      stamp = cyc;
      vld[w] = 1'b0;
      // Captured operands must survive the inputs changing right after the accept
      pk_data = ~pk_data;
      pk_kern = ~pk_kern;
      pk_bias = ~pk_bias;
   endtask

   task automatic drain(input int w);
      int k;
      int left;
      k = 0;
      left = (w == 0) ? qa.size() : (w == 1) ? qb.size() : qc.size();
      while (left != 0 && k < 300) begin
         @(negedge clk);
         k++;
         left = (w == 0) ? qa.size() : (w == 1) ? qb.size() : qc.size();
      end
      chk($sformatf("u%0d_drain_timeout", w), 64'(left), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int k;
      int sc[3];

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(a_if.in_ready), 64'd1);
      chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
      chk("rst_data_o", 64'(a_if.data_o), 64'd0);
      chk("rst_out_idx", 64'(a_if.out_idx), 64'd0);
      chk("rst_out_last", 64'(a_if.out_last), 64'd0);
      chk("rst_c_in_ready", 64'(c_if.in_ready), 64'd1);

      // All-ones vector, accepted on the first edge after reset release
      for (int i = 0; i < 12; i++) data_v[i] = 1;
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 12; i++) kern_v[n][i] = 1;
         bias_v[n] = 0;
      end
      ordy = 3'b111;
      rst = 1'b0;
      ta.delete();
      send(0, s);
      drain(0);
      chk("ones_result_count", 64'(ta.size()), 64'd4);
      if (ta.size() == 4) begin
         chk("ones_first_latency", 64'(ta[0] - s), 64'd4);
         for (int j = 1; j < 4; j++) chk("ones_spacing", 64'(ta[j] - ta[j-1]), 64'd4);
      end
      chk("ones_in_ready_after", 64'(a_if.in_ready), 64'd1);

      // Most negative data times most negative weights: no overflow
      for (int i = 0; i < 12; i++) data_v[i] = -32768;
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 12; i++) kern_v[n][i] = -128;
         bias_v[n] = n;
      end
      send(0, s);
      drain(0);
      chk("extreme_model_sanity", 64'(model(3, 1'b0)), 64'd50331651);

      repeat (2) begin
         rand_vec();
         send(0, s);
         drain(0);
      end

      // Stall on idx 2; in_valid pulses while busy must be ignored
      rand_vec();
      ordy[0] = 1'b0;
      send(0, s);
      vld[0] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("busy_in_ready", 64'(rdy[0]), 64'd0);
      end
      vld[0] = 1'b0;
      for (int n = 0; n < 4; n++) begin
         k = 0;
         while (!a_if.out_valid && k < 50) begin
            @(negedge clk);
            k++;
         end
         chk("stall_out_valid_rise", 64'(a_if.out_valid), 64'd1);
         if (n == 2) begin
            repeat (5) begin
               chk("stall_out_valid", 64'(a_if.out_valid), 64'd1);
               chk("stall_out_idx", 64'(a_if.out_idx), 64'd2);
               if (qa.size() > 0) chk("stall_data_o", 64'(a_if.data_o), 64'(qa[0].val));
               chk("stall_in_ready", 64'(a_if.in_ready), 64'd0);
               @(negedge clk);
            end
         end
         @(posedge clk);
         #1;
         ordy[0] = 1'b1;
         @(posedge clk);
         #1;
         ordy[0] = 1'b0;
      end
      chk("stall_queue_empty", 64'(qa.size()), 64'd0);

      // Reset while computing idx 1 abandons the vector
      ordy[0] = 1'b1;
      rand_vec();
      send(0, s);
      k = 0;
      while (qa.size() > 3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      qa.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midreset_out_valid", 64'(a_if.out_valid), 64'd0);
      chk("midreset_in_ready", 64'(a_if.in_ready), 64'd1);
      chk("midreset_out_idx", 64'(a_if.out_idx), 64'd0);
      rand_vec();
      send(0, s);
      drain(0);

      // ReLU variant
      for (int i = 0; i < 12; i++) data_v[i] = 1;
      for (int n = 0; n < 4; n++)
         for (int i = 0; i < 12; i++) kern_v[n][i] = -1;
      bias_v[0] = 0;
      bias_v[1] = 20;
      bias_v[2] = 5;
      bias_v[3] = 100;
      chk("relu_model_idx1", 64'(model(1, 1'b1)), 64'd8);
      send(1, s);
      drain(1);
      chk("relu_result_count", 64'(tb_s.size()), 64'd4);

      // Single-neuron, single-cycle MAC, back-to-back vectors
      tc.delete();
      for (int j = 0; j < 3; j++) begin
         rand_vec();
         send(2, sc[j]);
      end
      drain(2);
      chk("wide_result_count", 64'(tc.size()), 64'd3);
      if (tc.size() == 3) begin
         for (int j = 0; j < 3; j++) chk("wide_latency", 64'(tc[j] - sc[j]), 64'd2);
      end
      for (int j = 1; j < 3; j++) chk("wide_accept_spacing", 64'(sc[j] - sc[j-1]), 64'd3);

      repeat (5) @(negedge clk);
      chk("final_qa_empty", 64'(qa.size()), 64'd0);
      chk("final_qb_empty", 64'(qb.size()), 64'd0);
      chk("final_qc_empty", 64'(qc.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
